shared_mem_arbiter: RTL and testbench

//  Round-robin arbiter that lets NCORE phase-free cores share one single-port data memory.

---
 rtl/shared_mem_arbiter.sv | 98 +++++++++
 tb/tb_shared_mem_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/shared_mem_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between NCORE cores.
// One access issued per cycle; loads return after RD_LAT cycles.
module shared_mem_arbiter #(
  parameter int NCORE  = 4,
  parameter int AW     = 16,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NCORE-1:0]    req,
  input  logic [NCORE-1:0]    we,
  input  logic [NCORE*AW-1:0] addr,
  input  logic [NCORE*DW-1:0] wdata,
  output logic [NCORE-1:0]    gnt,
  output logic [NCORE-1:0]    rvalid,
  output logic [DW-1:0]       rdata,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  output logic                mem_we,
  input  logic [DW-1:0]       mem_q,
  output logic [15:0]         stall_cnt
);

  localparam int IDW = $clog2(NCORE);

  logic [IDW-1:0]              rr_ptr;
  logic [IDW-1:0]              gnt_id;
  logic [NCORE-1:0]            elig;
  logic [NCORE-1:0]            win_oh;
  logic [IDW-1:0]              win_id;
  logic                        win_vld;
  logic                        stall;
  logic [RD_LAT-1:0]           sr_v;
  logic [RD_LAT-1:0][IDW-1:0]  sr_id;
  logic [DW-1:0]               rdata_q;
  int                          cand;

  // A core shown gnt this cycle still holds req, so it is masked out.
  always_comb begin
    elig    = req & ~gnt;
    win_vld = 1'b0;
    win_id  = '0;
    cand    = 0;
    for (int k = NCORE - 1; k >= 0; k--) begin
      cand = (int'(rr_ptr) + k) % NCORE;
      if (elig[cand[IDW-1:0]]) begin
        win_vld = 1'b1;
        win_id  = cand[IDW-1:0];
      end
    end
    win_oh         = '0;
    win_oh[win_id] = win_vld;
    stall          = |(req & ~gnt & ~win_oh);
  end

  always_comb begin
    rvalid                = '0;
    rvalid[sr_id[RD_LAT-1]] = sr_v[RD_LAT-1];
  end

  assign rdata = sr_v[RD_LAT-1] ? mem_q : rdata_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      gnt       <= '0;
      gnt_id    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rr_ptr    <= '0;
      sr_v      <= '0;
      sr_id     <= '0;
      rdata_q   <= '0;
      stall_cnt <= '0;
    end else begin
      gnt    <= win_oh;
      mem_we <= win_vld & we[win_id];
      if (win_vld) begin
        gnt_id    <= win_id;
        mem_addr  <= addr[win_id*AW +: AW];
        mem_wdata <= wdata[win_id*DW +: DW];
        rr_ptr    <= (win_id == IDW'(NCORE - 1)) ? '0 : win_id + 1'b1;
      end
      sr_v[0]  <= (|gnt) & ~mem_we;
      sr_id[0] <= gnt_id;
      for (int k = 1; k < RD_LAT; k++) begin
        sr_v[k]  <= sr_v[k-1];
        sr_id[k] <= sr_id[k-1];
      end
      if (sr_v[RD_LAT-1])
        rdata_q <= mem_q;
      if (stall && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Directed bench for shared_mem_arbiter with a one-cycle-latency memory model.
// Expected values are hand-derived from the arbitration and read-return timing.
module tb_shared_mem_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  req;
  logic [3:0]  we;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [3:0]  gnt;
  logic [3:0]  rvalid;
  logic [15:0] rdata;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic [15:0] mem_q;
  logic [15:0] stall_cnt;

  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [15:0] pl_data;
  logic [15:0] mem [256];

  int checks = 0;
  int failures = 0;

  shared_mem_arbiter dut (
    .CLK(CLK), .RST(RST), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_q(mem_q),
    .stall_cnt(stall_cnt)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (pl_en)
      mem[pl_addr] <= pl_data;
    else if (mem_we)
      mem[mem_addr[7:0]] <= mem_wdata;
    mem_q <= mem[mem_addr[7:0]];
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 32'h0);
    chk({tag, "_rvalid"}, 32'(rvalid), 32'h0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'h0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'h0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'h0);
    chk({tag, "_rdata"}, 32'(rdata), 32'h0);
    chk({tag, "_stall"}, 32'(stall_cnt), 32'h0);
  endtask

  initial begin
    RST = 1'b1; req = '0; we = '0; addr = '0; wdata = '0;
    pl_en = 1'b1; pl_addr = 8'h40; pl_data = 16'hBEEF;
    tick();
    tick();
    pl_en = 1'b0;
    chk_reset_state("rst");

    // single load by core2
    RST = 1'b0;
    req = 4'b0100; we = 4'b0000; addr[32 +: 16] = 16'h0040;
    tick();
    chk("t1_gnt", 32'(gnt), 32'h4);
    chk("t1_addr", 32'(mem_addr), 32'h0040);
    chk("t1_we", 32'(mem_we), 32'h0);
    chk("t1_rv0", 32'(rvalid), 32'h0);
    tick();
    chk("t1_gnt_masked", 32'(gnt), 32'h0);
    chk("t1_rvalid", 32'(rvalid), 32'h4);
    chk("t1_rdata", 32'(rdata), 32'hBEEF);
    req = 4'b0000;
    tick();
    chk("t1_rv_done", 32'(rvalid), 32'h0);
    chk("t1_rdata_hold", 32'(rdata), 32'hBEEF);

    // core1 stores 0x1234 to 0x0010, then core3 loads it back
    req = 4'b0010; we = 4'b0010;
    addr[16 +: 16] = 16'h0010; wdata[16 +: 16] = 16'h1234;
    addr[48 +: 16] = 16'h0010;
    tick();
    chk("t2_gnt_st", 32'(gnt), 32'h2);
    chk("t2_we_st", 32'(mem_we), 32'h1);
    chk("t2_addr_st", 32'(mem_addr), 32'h0010);
    chk("t2_wdata_st", 32'(mem_wdata), 32'h1234);
    req = 4'b1010;
    tick();
    chk("t2_gnt_ld", 32'(gnt), 32'h8);
    chk("t2_we_ld", 32'(mem_we), 32'h0);
    chk("t2_addr_ld", 32'(mem_addr), 32'h0010);
    chk("t2_rv_store", 32'(rvalid), 32'h0);
    req = 4'b1000;
    tick();
    chk("t2_rvalid", 32'(rvalid), 32'h8);
    chk("t2_rdata", 32'(rdata), 32'h1234);
    chk("t2_we_idle", 32'(mem_we), 32'h0);
    req = 4'b0000;
    tick();
    chk("t2_rv_done", 32'(rvalid), 32'h0);

    // full contention from rr_ptr=0
    RST = 1'b1;
    tick();
    RST = 1'b0; req = 4'b1111; we = 4'b0000;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk($sformatf("t3_gnt%0d", k), 32'(gnt), 32'(4'b0001 << (k % 4)));
    end
    req = 4'b0000;
    chk("t3_stall", 32'(stall_cnt), 32'd12);
    tick();
    chk("t3_idle", 32'(gnt), 32'h0);

    // lone requester: masked every other cycle, no stall counted
    RST = 1'b1;
    tick();
    RST = 1'b0; req = 4'b0001; addr[0 +: 16] = 16'h0040;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk($sformatf("t4_gnt%0d", k), 32'(gnt), (k % 2 == 0) ? 32'h1 : 32'h0);
    end
    chk("t4_stall", 32'(stall_cnt), 32'h0);
    req = 4'b0000;

    // reset the cycle after a load grant
    RST = 1'b1;
    tick();
    RST = 1'b0; req = 4'b0100; we = 4'b0000;
    tick();
    chk("t6_gnt", 32'(gnt), 32'h4);
    tick();
    chk("t6_rvalid", 32'(rvalid), 32'h4);
    RST = 1'b1; req = 4'b1010;
    tick();
    chk_reset_state("t6_rst");
    RST = 1'b0;
    tick();
    chk("t6_gnt_low", 32'(gnt), 32'h2);
    chk("t6_rv_flushed", 32'(rvalid), 32'h0);
    tick();
    chk("t6_gnt_next", 32'(gnt), 32'h8);
    chk("t6_rv_core1", 32'(rvalid), 32'h2);
    req = 4'b0000;
    tick();

    // stall counter saturation
    RST = 1'b1;
    tick();
    RST = 1'b0; req = 4'b1111;
    repeat (65534) tick();
    chk("t5_fffe", 32'(stall_cnt), 32'hFFFE);
    tick();
    chk("t5_ffff", 32'(stall_cnt), 32'hFFFF);
    repeat (10) tick();
    chk("t5_sat", 32'(stall_cnt), 32'hFFFF);
    req = 4'b0000;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
